// File: rtl/sdram_req_queue.sv
// Host request FIFO plus single-outstanding issuer for the SDRAM controller's
// AHB-style slave port, with a per-transaction completion watchdog.
module sdram_req_queue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        in_HCLK,
  input  logic        in_HRESET,
  input  logic        in_req_valid,
  input  logic        in_req_write,
  input  logic [31:0] in_req_addr,
  input  logic [31:0] in_req_wdata,
  output logic        out_req_ready,
  output logic        out_HSEL,
  output logic        out_HWRITE,
  output logic [31:0] out_HADDR,
  output logic [31:0] out_HWDATA,
  input  logic        in_HREADY,
  input  logic [31:0] in_HRDATA,
  output logic        out_rsp_valid,
  output logic        out_rsp_write,
  output logic [31:0] out_rsp_rdata,
  output logic        out_rsp_err,
  output logic        out_busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [PW:0]   COUNT_FULL = (PW + 1)'(DEPTH);
  localparam logic [PW:0]   COUNT_ONE  = (PW + 1)'(1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    GAP
  } state_t;

  state_t state;
  state_t state_next;

  logic [64:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          push;
  logic          pop;
  logic          fifo_empty;

  logic          hold_write;
  logic [31:0]   hold_addr;
  logic [31:0]   hold_wdata;
  logic [TW-1:0] timer;
  logic          timer_expired;

  logic          rsp_write;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  assign fifo_empty    = (count == '0);
  assign out_req_ready = !in_HRESET && (count != COUNT_FULL);
  assign push          = in_req_valid && out_req_ready;
  assign pop           = (state == IDLE) && !fifo_empty;
  assign timer_expired = (timer == TIMER_LAST);

  always_ff @(posedge in_HCLK) begin
    if (push) begin
      mem[wr_ptr] <= {in_req_write, in_req_addr, in_req_wdata};
    end
  end

  always_ff @(posedge in_HCLK) begin
    if (in_HRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge in_HCLK) begin
    if (in_HRESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // HREADY wins over expiry when both land on the same edge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (in_HREADY || timer_expired) state_next = RESP;
      RESP:    state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge in_HCLK) begin
    if (in_HRESET) begin
      hold_write <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      timer      <= '0;
      rsp_write  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (pop) begin
        {hold_write, hold_addr, hold_wdata} <= mem[rd_ptr];
      end
      if (state == WAIT && !in_HREADY && !timer_expired) begin
        timer <= timer + TIMER_ONE;
      end else begin
        timer <= '0;
      end
      if (state == WAIT) begin
        if (in_HREADY) begin
          rsp_write <= hold_write;
          rsp_rdata <= hold_write ? 32'h0 : in_HRDATA;
          rsp_err   <= 1'b0;
        end else if (timer_expired) begin
          rsp_write <= hold_write;
          rsp_rdata <= 32'h0;
          rsp_err   <= 1'b1;
        end
      end
    end
  end

  // Controller-facing outputs read 0 for as long as reset is held.
  assign out_HSEL   = !in_HRESET && (state == ISSUE);
  assign out_HWRITE = !in_HRESET && hold_write;
  assign out_HADDR  = in_HRESET ? 32'h0 : hold_addr;
  assign out_HWDATA = in_HRESET ? 32'h0 : hold_wdata;

  assign out_rsp_valid = (state == RESP);
  assign out_rsp_write = (state == RESP) && rsp_write;
  assign out_rsp_rdata = (state == RESP) ? rsp_rdata : 32'h0;
  assign out_rsp_err   = (state == RESP) && rsp_err;
  assign out_busy      = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_sdram_req_queue.sv
// Randomized bench for sdram_req_queue against a timestamp-based model of the
// queue and the single outstanding transaction.
module tb_sdram_req_queue;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        in_HRESET = 1'b1;
  logic        in_req_valid = 1'b0;
  logic        in_req_write = 1'b0;
  logic [31:0] in_req_addr = '0;
  logic [31:0] in_req_wdata = '0;
  logic        out_req_ready;
  logic        out_HSEL;
  logic        out_HWRITE;
  logic [31:0] out_HADDR;
  logic [31:0] out_HWDATA;
  logic        in_HREADY = 1'b0;
  logic [31:0] in_HRDATA = '0;
  logic        out_rsp_valid;
  logic        out_rsp_write;
  logic [31:0] out_rsp_rdata;
  logic        out_rsp_err;
  logic        out_busy;

  always #5 clk = ~clk;

  sdram_req_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .in_HCLK      (clk),
    .in_HRESET    (in_HRESET),
    .in_req_valid (in_req_valid),
    .in_req_write (in_req_write),
    .in_req_addr  (in_req_addr),
    .in_req_wdata (in_req_wdata),
    .out_req_ready(out_req_ready),
    .out_HSEL     (out_HSEL),
    .out_HWRITE   (out_HWRITE),
    .out_HADDR    (out_HADDR),
    .out_HWDATA   (out_HWDATA),
    .in_HREADY    (in_HREADY),
    .in_HRDATA    (in_HRDATA),
    .out_rsp_valid(out_rsp_valid),
    .out_rsp_write(out_rsp_write),
    .out_rsp_rdata(out_rsp_rdata),
    .out_rsp_err  (out_rsp_err),
    .out_busy     (out_busy)
  );

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
  } req_t;

  // Model: pending queue plus the edge numbers at which the in-flight
  // transaction is selected and answered.
  req_t        q[$];
  req_t        cur;
  bit          inflight = 0;
  bit          resolved = 0;
  bit          known = 0;
  int          sel_e = 0;
  int          rsp_e = 0;
  bit          r_write = 0;
  bit          r_err = 0;
  logic [31:0] r_data = '0;
  int          cyc = 0;
  bit          last_accepted = 0;

  int checks = 0;
  int passes = 0;

  bit          h_v = 0;
  bit          h_w = 0;
  logic [31:0] h_a = '0;
  logic [31:0] h_d = '0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", tag, obs, exp, cyc);
  endtask

  task automatic applyStimulus(input bit r, input bit v, input bit w, input logic [31:0] a,
                               input logic [31:0] d, input bit hr, input logic [31:0] hd);
    int   e;
    int   size_before;
    bit   exp_ready;
    bit   exp_rv;
    bit   exp_busy;
    bit   window;
    req_t nr;
    @(negedge clk);
    in_HRESET    = r;
    in_req_valid = v;
    in_req_write = w;
    in_req_addr  = a;
    in_req_wdata = d;
    in_HREADY    = hr;
    in_HRDATA    = hd;
    #1;
    e         = cyc;
    exp_ready = !r && (q.size() < DEPTH);
    window    = inflight && (e >= sel_e) && (!resolved || e < rsp_e);
    checkOutput("req_ready", out_req_ready, exp_ready);
    checkOutput("hsel", out_HSEL, !r && inflight && (e == sel_e));
    if (r) begin
      checkOutput("hwrite_rst", out_HWRITE, 0);
      checkOutput("haddr_rst", out_HADDR, 0);
      checkOutput("hwdata_rst", out_HWDATA, 0);
    end else if (window) begin
      checkOutput("hwrite", out_HWRITE, cur.w);
      checkOutput("haddr", out_HADDR, cur.a);
      checkOutput("hwdata", out_HWDATA, cur.d);
    end
    if (known) begin
      exp_rv   = inflight && resolved && (e == rsp_e);
      exp_busy = (q.size() != 0) || (inflight && !(resolved && e >= rsp_e + 2));
      checkOutput("rsp_valid", out_rsp_valid, exp_rv);
      checkOutput("busy", out_busy, exp_busy);
      if (exp_rv) begin
        checkOutput("rsp_write", out_rsp_write, r_write);
        checkOutput("rsp_rdata", out_rsp_rdata, r_data);
        checkOutput("rsp_err", out_rsp_err, r_err);
      end
    end
    last_accepted = v && exp_ready;
    @(posedge clk);
    if (r) begin
      q.delete();
      inflight = 0;
      resolved = 0;
      known    = 1;
    end else begin
      if (inflight && !resolved && e > sel_e) begin
        if (hr) begin
          resolved = 1; rsp_e = e + 1; r_err = 0; r_write = cur.w;
          r_data = cur.w ? 32'h0 : hd;
        end else if (e == sel_e + TIMEOUT) begin
          resolved = 1; rsp_e = e + 1; r_err = 1; r_write = cur.w; r_data = 32'h0;
        end
      end
      if (inflight && resolved && e == rsp_e + 2) inflight = 0;
      size_before = q.size();
      if (!inflight && size_before != 0) begin
        cur      = q.pop_front();
        inflight = 1;
        resolved = 0;
        sel_e    = e + 1;
      end
      if (last_accepted) begin
        nr.w = w; nr.a = a; nr.d = d;
        q.push_back(nr);
      end
    end
    cyc++;
  endtask

  task automatic hostCycle(input bit r, input bit hr);
    applyStimulus(r, h_v, h_w, h_a, h_d, hr, $urandom);
    if (last_accepted) begin
      h_w = 1'($urandom_range(0, 1));
      h_a = $urandom;
      h_d = $urandom;
    end
  endtask

  initial begin
    int pushes_left;
    int hr_div;
    h_w = 1'b1; h_a = $urandom; h_d = $urandom;

    $display("[TB] reset held with request valid");
    h_v = 1;
    for (int i = 0; i < 3; i++) hostCycle(1, 1'($urandom_range(0, 1)));
    h_v = 0;

    $display("[TB] single write then read");
    applyStimulus(0, 1, 1, 32'h0000_0040, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    applyStimulus(0, 1, 0, 32'h0000_0040, 32'h0, 1, 32'hDEAD_BEEF);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);

    $display("[TB] fill queue with controller stalled");
    pushes_left = 5;
    for (int i = 0; i < 30; i++) begin
      h_v = (pushes_left > 0);
      hostCycle(0, 0);
      if (last_accepted) pushes_left--;
    end
    h_v = 0;
    for (int i = 0; i < 60; i++) hostCycle(0, 1);

    $display("[TB] HREADY on the expiry edge");
    applyStimulus(0, 1, 0, 32'h0000_1234, 32'h0, 0, 32'h0);
    for (int i = 0; i < 25; i++)
      applyStimulus(0, 0, 0, 0, 0, inflight && !resolved && (cyc == sel_e + TIMEOUT), 32'hCAFE_F00D);

    $display("[TB] reset during WAIT");
    applyStimulus(0, 1, 1, 32'h0000_0080, 32'h1111_2222, 0, 32'h0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 1, $urandom);

    $display("[TB] randomized traffic");
    hr_div = 2;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) hr_div = (i / 200 % 3 == 0) ? 2 : ((i / 200 % 3 == 1) ? 8 : 30);
      if (!h_v) h_v = ($urandom_range(0, 9) < 7);
      hostCycle($urandom_range(0, 299) == 0, $urandom_range(0, hr_div - 1) == 0);
      if (last_accepted) h_v = ($urandom_range(0, 9) < 7);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
